// File: rtl/qtree_mm_writer_if.sv
// qtree_mm_writer_if: command channel into the MM writer and the registered
// write port it drives toward the lookup engine.
//   cmd_addr_i/cmd_data_i/cmd_valid_i : command from the config side
//   cmd_ready_o                       : command accepted when high with valid
//   mm_ctrl_addr_o/data_o/write_o     : single-cycle write strobe to the engine
// Modports: master = command source, slave = the writer.
interface qtree_mm_writer_if #(
   parameter int unsigned MM_ADDR_WIDTH = 8,
   parameter int unsigned MM_DATA_WIDTH = 128
);
   logic [MM_ADDR_WIDTH-1:0] cmd_addr_i;
   logic [MM_DATA_WIDTH-1:0] cmd_data_i;
   logic                     cmd_valid_i;
   logic                     cmd_ready_o;
   logic [MM_ADDR_WIDTH-1:0] mm_ctrl_addr_o;
   logic [MM_DATA_WIDTH-1:0] mm_ctrl_data_o;
   logic                     mm_ctrl_write_o;

   modport master (
      output cmd_addr_i, cmd_data_i, cmd_valid_i,
      input  cmd_ready_o, mm_ctrl_addr_o, mm_ctrl_data_o, mm_ctrl_write_o
   );

   modport slave (
      input  cmd_addr_i, cmd_data_i, cmd_valid_i,
      output cmd_ready_o, mm_ctrl_addr_o, mm_ctrl_data_o, mm_ctrl_write_o
   );
endinterface

// File: rtl/qtree_mm_writer.sv
// qtree_mm_writer: buffers table-update commands in a small FIFO and issues
// them as registered single-cycle MM write strobes; on request, sweeps the
// whole MM address space with zero data after the queue has drained.
//   clk_i        : clock
//   rst_i        : asynchronous reset, active low
//   bus          : command handshake + MM write port (slave side)
//   clear_req_i  : one-cycle pulse requesting a zero sweep
//   pause_i      : hold off issuing writes; FIFO and sweep address hold
//   busy_o       : FIFO non-empty, sweep pending or sweeping
//   wr_cnt_o     : total strobes issued, wrapping
module qtree_mm_writer #(
   parameter int unsigned MM_ADDR_WIDTH = 8,
   parameter int unsigned MM_DATA_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   qtree_mm_writer_if.slave     bus,
   input  logic                 clear_req_i,
   input  logic                 pause_i,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] wr_cnt_o
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state, state_nxt;

   logic [MM_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
   logic [MM_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W:0]           wr_ptr, rd_ptr;
   logic                     fifo_empty, fifo_full;
   logic                     push, pop, sweep_issue, sweep_last, clear_start;
   logic                     clear_pend, cmd_ready;
   logic [MM_ADDR_WIDTH-1:0] sweep_addr;
   logic [MM_ADDR_WIDTH-1:0] mm_addr;
   logic [MM_DATA_WIDTH-1:0] mm_data;
   logic                     mm_write;
   logic [CNT_WIDTH-1:0]     wr_cnt;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push       = bus.cmd_valid_i && cmd_ready;
   assign sweep_last = (sweep_addr == '1);

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (clear_start)               state_nxt = CLEAR;
         CLEAR: if (sweep_issue && sweep_last) state_nxt = IDLE;
      endcase
   end

   // Per-state control outputs
   always_comb begin
      cmd_ready   = 1'b0;
      pop         = 1'b0;
      clear_start = 1'b0;
      sweep_issue = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready   = !fifo_full && !clear_pend;
            pop         = !fifo_empty && !pause_i;
            // Sweep waits for the queue to drain.
            clear_start = clear_pend && fifo_empty;
         end
         CLEAR: sweep_issue = !pause_i;
      endcase
   end

   // Sweep request latch and sweep address
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         clear_pend <= 1'b0;
         sweep_addr <= '0;
      end else begin
         if (clear_start)
            clear_pend <= 1'b0;
         else if (clear_req_i && state == IDLE)
            clear_pend <= 1'b1;

         if (clear_start)
            sweep_addr <= '0;
         else if (sweep_issue)
            sweep_addr <= sweep_addr + MM_ADDR_WIDTH'(1);
      end
   end

   // FIFO storage (no reset needed; pointers define validity)
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr[wr_ptr[PTR_W-1:0]] <= bus.cmd_addr_i;
         fifo_data[wr_ptr[PTR_W-1:0]] <= bus.cmd_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Registered MM write port; address/data hold when no strobe.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mm_write <= 1'b0;
         mm_addr  <= '0;
         mm_data  <= '0;
         wr_cnt   <= '0;
      end else begin
         mm_write <= pop || sweep_issue;
         if (pop) begin
            mm_addr <= fifo_addr[rd_ptr[PTR_W-1:0]];
            mm_data <= fifo_data[rd_ptr[PTR_W-1:0]];
         end else if (sweep_issue) begin
            mm_addr <= sweep_addr;
            mm_data <= '0;
         end
         if (mm_write) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      end
   end

   assign bus.cmd_ready_o     = cmd_ready;
   assign bus.mm_ctrl_addr_o  = mm_addr;
   assign bus.mm_ctrl_data_o  = mm_data;
   assign bus.mm_ctrl_write_o = mm_write;
   assign busy_o              = !fifo_empty || clear_pend || (state == CLEAR);
   assign wr_cnt_o            = wr_cnt;
endmodule

// File: tb/tb_qtree_mm_writer.sv
// tb_qtree_mm_writer: directed bench for qtree_mm_writer (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_qtree_mm_writer;
   logic        clk = 1'b0;
   logic        rst;
   logic        clear_req;
   logic        pause;
   logic        busy;
   logic [15:0] wr_cnt;

   always #5 clk = ~clk;

   qtree_mm_writer_if #(.MM_ADDR_WIDTH(8), .MM_DATA_WIDTH(128)) bus ();

   qtree_mm_writer #(
      .MM_ADDR_WIDTH(8),
      .MM_DATA_WIDTH(128),
      .FIFO_DEPTH(4),
      .CNT_WIDTH(16)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus),
      .clear_req_i(clear_req),
      .pause_i    (pause),
      .busy_o     (busy),
      .wr_cnt_o   (wr_cnt)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Strobe monitor: records every strobe and flags strobes that follow a paused edge.
   logic [7:0]   sa[$];
   logic [127:0] sd[$];
   int unsigned  pause_viol = 0;
   logic         pause_q = 1'b0;

   always @(posedge clk) pause_q = pause;

   always @(negedge clk) begin
      if (rst === 1'b1 && bus.mm_ctrl_write_o === 1'b1) begin
         sa.push_back(bus.mm_ctrl_addr_o);
         sd.push_back(bus.mm_ctrl_data_o);
         if (pause_q) pause_viol++;
      end
   end

   task automatic push(input logic [7:0] a, input logic [127:0] d);
      bit ok = 1'b0;
      bus.cmd_addr_i  = a;
      bus.cmd_data_i  = d;
      bus.cmd_valid_i = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (bus.cmd_ready_o) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.cmd_valid_i = 1'b0;
      check("push_accepted", ok, 1'b1);
   endtask

   task automatic wait_idle(input string tag, input int unsigned limit);
      int unsigned i = 0;
      while (busy && i < limit) begin
         @(negedge clk);
         i++;
      end
      check(tag, busy, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0]  a;
      int unsigned accepted;
      int unsigned errs;
      int unsigned ready_viol;
      int unsigned guard;

      rst = 1'b0;
      clear_req = 1'b0;
      pause = 1'b0;
      bus.cmd_addr_i  = '0;
      bus.cmd_data_i  = '0;
      bus.cmd_valid_i = 1'b0;

      // ---- reset values ----
      repeat (2) @(negedge clk);
      check("rst_write", bus.mm_ctrl_write_o, 1'b0);
      check("rst_addr",  bus.mm_ctrl_addr_o, 8'h00);
      check("rst_data",  bus.mm_ctrl_data_o, 128'h0);
      check("rst_cnt",   wr_cnt, 16'h0);
      check("rst_busy",  busy, 1'b0);
      check("rst_ready", bus.cmd_ready_o, 1'b1);
      rst = 1'b1;
      @(negedge clk);

      // ---- single write, latency ----
      push(8'h05, {16{8'hA5}});
      check("t1_no_strobe_yet", bus.mm_ctrl_write_o, 1'b0);
      check("t1_busy", busy, 1'b1);
      @(negedge clk);
      check("t1_strobe", bus.mm_ctrl_write_o, 1'b1);
      check("t1_addr", bus.mm_ctrl_addr_o, 8'h05);
      check("t1_data", bus.mm_ctrl_data_o, {16{8'hA5}});
      @(negedge clk);
      check("t1_one_strobe", bus.mm_ctrl_write_o, 1'b0);
      check("t1_addr_hold", bus.mm_ctrl_addr_o, 8'h05);
      check("t1_cnt", wr_cnt, 16'd1);
      check("t1_busy_low", busy, 1'b0);

      // ---- paused fill, full FIFO, drain ----
      sa.delete(); sd.delete();
      pause = 1'b1;
      accepted = 0;
      for (int k = 0; k < 6; k++) begin
         a = 8'h10 + 8'(k);
         bus.cmd_addr_i  = a;
         bus.cmd_data_i  = {16{a}};
         bus.cmd_valid_i = 1'b1;
         if (bus.cmd_ready_o) accepted++;
         @(negedge clk);
      end
      bus.cmd_valid_i = 1'b0;
      check("t2_accepted", accepted, 4);
      check("t2_ready_full", bus.cmd_ready_o, 1'b0);
      check("t2_no_strobe_paused", sa.size(), 0);
      pause = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t2_burst_strobe", bus.mm_ctrl_write_o, 1'b1);
         check("t2_burst_addr", bus.mm_ctrl_addr_o, 8'h10 + 8'(k));
      end
      push(8'h14, {16{8'h14}});
      push(8'h15, {16{8'h15}});
      wait_idle("t2_drain", 50);
      check("t2_strobe_count", sa.size(), 6);
      errs = 0;
      for (int k = 0; k < 6 && k < sa.size(); k++) begin
         a = 8'h10 + 8'(k);
         if (sa[k] !== a || sd[k] !== {16{a}}) errs++;
      end
      check("t2_order", errs, 0);
      check("t2_cnt", wr_cnt, 16'd7);

      // ---- queued commands then sweep ----
      do_reset();
      sa.delete(); sd.delete();
      pause = 1'b1;
      push(8'h81, {8{16'h8181}});
      push(8'h02, {8{16'h0202}});
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      check("t3_ready_pend", bus.cmd_ready_o, 1'b0);
      pause = 1'b0;
      ready_viol = 0;
      guard = 0;
      while (busy && guard < 1000) begin
         if (bus.cmd_ready_o) ready_viol++;
         @(negedge clk);
         guard++;
      end
      check("t3_done", busy, 1'b0);
      check("t3_ready_low", ready_viol, 0);
      repeat (2) @(negedge clk);
      check("t3_strobe_count", sa.size(), 258);
      if (sa.size() >= 2) begin
         check("t3_first_addr", sa[0], 8'h81);
         check("t3_first_data", sd[0], {8{16'h8181}});
         check("t3_second_addr", sa[1], 8'h02);
      end
      errs = 0;
      for (int k = 2; k < sa.size(); k++)
         if (sa[k] !== 8'(k - 2) || sd[k] !== 128'h0) errs++;
      check("t3_sweep_seq", errs, 0);
      check("t3_cnt", wr_cnt, 16'd258);
      check("t3_ready_back", bus.cmd_ready_o, 1'b1);

      // ---- sweep latency and random pause ----
      sa.delete(); sd.delete();
      pause_viol = 0;
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      check("t4_lat_n0", bus.mm_ctrl_write_o, 1'b0);
      @(negedge clk);
      check("t4_lat_n1", bus.mm_ctrl_write_o, 1'b0);
      @(negedge clk);
      check("t4_lat_n2", bus.mm_ctrl_write_o, 1'b1);
      check("t4_first_addr", bus.mm_ctrl_addr_o, 8'h00);
      guard = 0;
      while (busy && guard < 2000) begin
         pause = 1'($urandom_range(0, 1));
         @(negedge clk);
         guard++;
      end
      pause = 1'b0;
      wait_idle("t4_done", 100);
      check("t4_strobe_count", sa.size(), 256);
      errs = 0;
      for (int k = 0; k < sa.size(); k++)
         if (sa[k] !== 8'(k) || sd[k] !== 128'h0) errs++;
      check("t4_sweep_seq", errs, 0);
      check("t4_pause_respected", pause_viol, 0);
      check("t4_cnt", wr_cnt, 16'd514);

      // ---- reset mid-sweep ----
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      guard = 0;
      while (!(bus.mm_ctrl_write_o && bus.mm_ctrl_addr_o == 8'h3F) && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check("t5_reached_3f", bus.mm_ctrl_addr_o, 8'h3F);
      rst = 1'b0;
      #1;
      check("t5_rst_write", bus.mm_ctrl_write_o, 1'b0);
      check("t5_rst_addr",  bus.mm_ctrl_addr_o, 8'h00);
      check("t5_rst_data",  bus.mm_ctrl_data_o, 128'h0);
      check("t5_rst_cnt",   wr_cnt, 16'h0);
      check("t5_rst_busy",  busy, 1'b0);
      check("t5_rst_ready", bus.cmd_ready_o, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sa.delete(); sd.delete();
      @(negedge clk);
      check("t5_no_strobe_after_release", bus.mm_ctrl_write_o, 1'b0);
      repeat (4) @(negedge clk);
      check("t5_no_strobes", sa.size(), 0);
      check("t5_busy", busy, 1'b0);

      // ---- counter wrap ----
      accepted = 0;
      guard = 0;
      bus.cmd_data_i  = '0;
      bus.cmd_valid_i = 1'b1;
      while (accepted < 65535 && guard < 70000) begin
         bus.cmd_addr_i = 8'(accepted);
         if (bus.cmd_ready_o) accepted++;
         @(negedge clk);
         guard++;
      end
      bus.cmd_valid_i = 1'b0;
      check("t6_accepted", accepted, 65535);
      wait_idle("t6_drain", 20);
      sa.delete(); sd.delete();
      check("t6_cnt_max", wr_cnt, 16'hFFFF);
      push(8'h33, 128'h1);
      wait_idle("t6_last", 20);
      check("t6_cnt_wrap", wr_cnt, 16'h0000);
      check("t6_last_addr", bus.mm_ctrl_addr_o, 8'h33);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
